// File: rtl/sys_console.sv
// sys_console: turns print/halt syscalls into an ASCII byte stream on a valid/ready interface.
// Integers are converted LSB-first onto a digit stack, then emitted MSB-first.
module sys_console #(
  parameter int SIGNED = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sys,
  input  logic [31:0] i_num,
  input  logic [31:0] i_op1,
  output logic        o_busy,
  output logic        o_valid,
  output logic [7:0]  o_data,
  input  logic        i_ready,
  output logic        o_halt
);
  typedef enum logic [2:0] {IDLE, CONV, SIGN, EMIT, CHAR, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] m_q, m_d, quo;
  logic [3:0]  rem;
  logic        neg_q, neg_d, neg_in, xfer;
  logic [39:0] stk_q, stk_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  chr_q, chr_d, data_q, data_d;
  logic        valid_q, valid_d, busy_q, busy_d, halt_q, halt_d;

  assign quo    = m_q / 32'd10;
  assign rem    = 4'(m_q % 32'd10);
  assign neg_in = (SIGNED != 0) && i_op1[31];
  assign xfer   = valid_q && i_ready;

  // Stack is a nibble shift register: push shifts left, so [3:0] is always the top (MSB digit).
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    neg_d   = neg_q;
    stk_d   = stk_q;
    cnt_d   = cnt_q;
    chr_d   = chr_q;
    unique case (state_q)
      IDLE: if (i_sys) begin
        if (i_num == 32'd2) begin
          m_d     = neg_in ? -i_op1 : i_op1;
          neg_d   = neg_in;
          cnt_d   = 4'd0;
          state_d = CONV;
        end else if (i_num == 32'd3) begin
          chr_d   = i_op1[7:0];
          state_d = CHAR;
        end else if (i_num == 32'd0) begin
          state_d = HALT;
        end
      end
      CONV: begin
        stk_d   = {stk_q[35:0], rem};
        cnt_d   = cnt_q + 4'd1;
        m_d     = quo;
        state_d = (quo != 32'd0) ? CONV : neg_q ? SIGN : EMIT;
      end
      SIGN: state_d = xfer ? EMIT : SIGN;
      EMIT: if (xfer) begin
        stk_d   = {4'h0, stk_q[39:4]};
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? IDLE : EMIT;
      end
      CHAR: state_d = xfer ? IDLE : CHAR;
      default: state_d = state_q;
    endcase
    busy_d  = state_d != IDLE;
    halt_d  = state_d == HALT;
    valid_d = (state_d == SIGN) || (state_d == EMIT) || (state_d == CHAR);
    data_d  = (state_d == SIGN) ? 8'h2D :
              (state_d == EMIT) ? 8'h30 + {4'h0, stk_d[3:0]} :
              (state_d == CHAR) ? chr_d : 8'h00;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      neg_q   <= 1'b0;
      stk_q   <= '0;
      cnt_q   <= '0;
      chr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      stk_q   <= stk_d;
      cnt_q   <= cnt_d;
      chr_q   <= chr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      halt_q  <= halt_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_halt  = halt_q;
endmodule

// File: tb/tb_sys_console.sv
// tb_sys_console: directed stimulus against a string/queue model of the console byte stream.
module tb_sys_console;
  logic        clk = 1'b0, rst = 1'b1, sys = 1'b0, ready = 1'b1;
  logic [31:0] num = '0, op = '0;
  logic        busy, valid, halt, u_busy, u_valid, u_halt;
  logic [7:0]  data, u_data;

  always #5 clk = ~clk;

  sys_console #(.SIGNED(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_sys(sys), .i_num(num), .i_op1(op),
    .o_busy(busy), .o_valid(valid), .o_data(data), .i_ready(ready), .o_halt(halt));
  sys_console #(.SIGNED(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_sys(sys), .i_num(num), .i_op1(op),
    .o_busy(u_busy), .o_valid(u_valid), .o_data(u_data), .i_ready(ready), .o_halt(u_halt));

  int errs = 0, checks = 0, busy_cyc = 0;
  string got = "", ugot = "", s;
  byte unsigned mq[$];
  int  m_conv = 0;
  bit  m_busy = 0, m_halt = 0, ev, pv = 0, pr = 0;
  logic [7:0] exp_d, pd = 0;

  function automatic string fmt(logic [31:0] v, bit sg);
    bit n = sg && v[31];
    logic [31:0] m = n ? -v : v;
    return n ? {"-", $sformatf("%0d", m)} : $sformatf("%0d", m);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chks(string nm, string act, string exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
    end
  endtask

  // Model: a request becomes its full output string; digits take one cycle each to appear.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_conv = 0;
      m_busy = 0;
      m_halt = 0;
    end else if (!m_busy) begin
      if (sys && num == 32'd2) begin
        s = fmt(op, 1'b1);
        for (int i = 0; i < s.len(); i++) mq.push_back(s[i]);
        m_conv = (s[0] == 8'h2D) ? s.len() - 1 : s.len();
        m_busy = 1;
      end else if (sys && num == 32'd3) begin
        mq.push_back(op[7:0]);
        m_conv = 0;
        m_busy = 1;
      end else if (sys && num == 32'd0) begin
        m_busy = 1;
        m_halt = 1;
      end
    end else if (m_halt) begin
      m_busy = 1;
    end else if (m_conv > 0) begin
      m_conv--;
    end else if (ready) begin
      void'(mq.pop_front());
      if (mq.size() == 0) m_busy = 0;
    end
  end

  always @(negedge clk) begin
    ev = m_busy && !m_halt && m_conv == 0 && mq.size() > 0;
    if (ev) exp_d = mq[0];
    else exp_d = 8'h00;
    chk("busy", busy, m_busy);
    chk("valid", valid, ev);
    chk("data", data, exp_d);
    chk("halt", halt, m_halt);
    if (pv && !pr && !rst) begin
      chk("hold_valid", valid, 1);
      chk("hold_data", data, pd);
    end
    pv = valid;
    pr = ready;
    pd = data;
    if (valid && ready) got = $sformatf("%s%c", got, data);
    if (u_valid && ready) ugot = $sformatf("%s%c", ugot, u_data);
    if (busy) busy_cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(logic [31:0] n, logic [31:0] o);
    got = "";
    ugot = "";
    busy_cyc = 0;
    sys = 1;
    num = n;
    op = o;
    tick();
    sys = 0;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while ((busy || u_busy) && n < 200) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, 32'(n < 200), 1);
    tick();
  endtask

  initial begin
    bit pat[5] = '{1, 1, 0, 0, 1};
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_halt", halt, 0);
    rst = 0;
    tick();

    req(3, 32'h41);
    wait_idle("char");
    chks("char_A", got, "A");
    chk("char_busy", busy_cyc, 1);

    req(2, 305);
    wait_idle("i305");
    chks("int_305", got, "305");
    chk("int_305_busy", busy_cyc, 6);

    req(2, 32'h80000000);
    wait_idle("min");
    chks("min_signed", got, "-2147483648");
    chks("min_unsigned", ugot, "2147483648");
    chk("min_busy", busy_cyc, 21);

    req(2, 0);
    wait_idle("zero");
    chks("zero", got, "0");
    chk("zero_busy", busy_cyc, 2);

    req(2, -32'sd7);
    foreach (pat[i]) begin
      ready = pat[i];
      tick();
    end
    ready = 1;
    wait_idle("neg7");
    chks("neg7", got, "-7");
    chk("neg7_xfers", got.len(), 2);
    chk("neg7_busy", busy_cyc, 5);

    req(5, 123);
    repeat (3) tick();
    chk("num5_busy", busy_cyc, 0);
    chks("num5_out", got, "");

    req(2, 305);
    sys = 1;
    num = 3;
    op = 32'h5A;
    tick();
    sys = 0;
    wait_idle("drop");
    chks("drop_busy_req", got, "305");

    req(2, 305);
    repeat (5) tick();
    chks("pre_rst", got, "30");
    rst = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_data", data, 0);
    tick();
    tick();
    rst = 0;
    tick();
    tick();
    chks("post_rst", got, "30");
    req(2, 42);
    wait_idle("i42");
    chks("int_42", got, "42");

    req(0, 0);
    chk("halt_set", halt, 1);
    chk("halt_busy", busy, 1);
    req(3, 32'h41);
    repeat (5) tick();
    chk("halt_sticky", halt, 1);
    chk("halt_busy_sticky", busy, 1);
    chks("halt_no_out", got, "");
    rst = 1;
    tick();
    rst = 0;
    tick();
    chk("halt_clr", halt, 0);
    chk("halt_clr_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sys_console.md
# sys_console

Console output stage fed by the syscall decode path. It accepts print requests (syscall number plus operand), turns them into an ASCII byte stream, and presents the stream on a valid/ready byte interface for a UART transmitter or simulation sink. It formats integers to decimal and passes characters through unchanged. It raises a pipeline stall while it is busy and a sticky halt flag on syscall 0.

## Interface
- `SIGNED`, default 1: 1 = syscall 2 treats `i_op1` as two's complement; 0 = unsigned.
- `i_clk` input 1: clock; all state updates on the rising edge.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_sys` input 1: print request valid; sampled only while `o_busy`=0.
- `i_num` input 32: syscall number (0 = halt, 2 = print integer, 3 = print char).
- `i_op1` input 32: operand.
- `o_busy` output 1: request in progress; upstream holds its request and stalls while this is high.
- `o_valid` output 1: byte valid.
- `o_data` output 8: ASCII byte.
- `i_ready` input 1: sink accepts the byte; a transfer occurs on any edge where `o_valid` && `i_ready`.
- `o_halt` output 1: halt requested; sticky until reset.

## Operation
- States: IDLE, CONV, SIGN, EMIT, CHAR, HALT.
- `o_busy` = (state != IDLE).
- IDLE, with `i_sys`=1 at the edge:
  - num 2: latch magnitude m and neg flag, then go to CONV.
    - neg = `SIGNED` && `i_op1[31]`.
    - m = neg ? -`i_op1` : `i_op1`, computed in 32-bit unsigned. 0x80000000 gives 2147483648.
  - num 3: latch `i_op1[7:0]`, then go to CHAR.
  - num 0: go to HALT.
  - any other num: ignored; stay in IDLE; no busy cycle.
- CONV, one cycle per digit:
  - Push m%10 onto a 10-entry digit stack, then m <= m/10.
  - /10 and %10 are combinational on 32 bits.
  - If the new m == 0, go to SIGN when neg, otherwise go to EMIT.
  - Value 0 takes exactly one CONV cycle and pushes digit 0.
- SIGN: `o_valid`=1, `o_data`=0x2D ('-'). On transfer, go to EMIT.
- EMIT: `o_valid`=1, `o_data`=0x30+top-of-stack, so digits leave MSB first.
  - On transfer, pop the stack.
  - When the popped digit was the last one, go to IDLE.
- CHAR: `o_valid`=1, `o_data`=latched byte. On transfer, go to IDLE.
- HALT: `o_halt`=1, `o_busy`=1, `o_valid`=0. Stays here until reset.
- Byte interface rules:
  - Once `o_valid` rises, `o_valid` and `o_data` hold stable until the transfer completes.
  - `o_valid` never depends combinationally on `i_ready`.
- Inputs `i_sys`, `i_num` and `i_op1` are ignored while `o_busy`=1. There is no queuing and no overflow condition.

## Timing
- Reset (async assert, edge-synchronous release):
  - state = IDLE.
  - `o_busy`=0, `o_valid`=0, `o_data`=0x00, `o_halt`=0.
  - Digit stack count = 0.
- Reset mid-request aborts the request immediately. Partial output is dropped and no further bytes are emitted.
- Request accepted at edge k: `o_busy`=1 from edge k onward.
- Integer with D digits and `i_ready` held high:
  - CONV occupies edges k+1 … k+D.
  - The first byte is valid after edge k+D.
  - One byte transfers per cycle.
  - Last transfer at edge k+D+D', where D' = D (+1 if neg). IDLE after that edge.
- Char request: `o_valid` from edge k to the transfer. At the earliest, IDLE after edge k+1.
- Halt: `o_halt`=1 and `o_busy`=1 from edge k.
- Back-to-back: a new request can be accepted on the edge right after the final transfer, i.e. the first edge where `o_busy`=0.
- Sink stall: any number of `i_ready`=0 cycles only extends SIGN, EMIT or CHAR. It never alters the byte sequence.

## Test plan
- Reset, then num 3 with op1=0x41 and `i_ready`=1 → a single byte 0x41 one cycle after acceptance; `o_busy` high for exactly 1 cycle.
- num 2 with op1=305 and `i_ready`=1 → 3 CONV cycles, then bytes 0x33, 0x30, 0x35 on consecutive cycles; `o_busy` high for 6 cycles.
- num 2 with op1=0x80000000, `SIGNED`=1 → "-2147483648" (11 bytes). Same input with `SIGNED`=0 → "2147483648". op1=0 → a single byte "0".
- num 2 with op1=-7 and `i_ready` toggling 1,0,0,1 → bytes '-', '7'; `o_data` stable during every stalled cycle; exactly 2 transfers.
- num 5 → no output and `o_busy` stays 0. A request with `i_sys`=1 while busy is dropped. num 0 → `o_halt`=1 sticky and `o_busy`=1; cleared only by `i_rst`.
- Assert `i_rst` after the second of three digit transfers → all outputs go to reset values immediately; the third digit never appears; the next request formats correctly.
